// File: rtl/req_encoder_4_2_pkg.sv
// Shared widths, FSM state encoding and index decode helper for the
// round-robin request encoder.
package req_encoder_4_2_pkg;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned N_REQ = 4;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        return N_REQ'(1) << idx;
    endfunction

endpackage : req_encoder_4_2_pkg

// File: rtl/req_encoder_4_2_rr_pick_4.sv
// Combinational round-robin picker: first set bit of cand scanning from ptr,
// wrapping 3->0.
module rr_pick_4
    import req_encoder_4_2_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [IDX_W-1:0] w_idx;

    // Scan offsets high to low so the smallest offset from ptr wins last.
    always_comb begin
        pick  = ptr;
        w_idx = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = IDX_W'(ptr + IDX_W'(i));
            if (cand[w_idx]) begin
                pick = w_idx;
            end
        end
    end

    assign any = |cand;

endmodule : rr_pick_4

// File: rtl/req_encoder_4_2.sv
// Registered 4-to-2 request encoder: sticky pending capture, round-robin
// selection and a valid/ready output handshake.
module req_encoder_4_2
    import req_encoder_4_2_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    input  logic             out_ready,
    input  logic             clr_ovr,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    output logic [N_REQ-1:0] out_onehot,
    output logic [N_REQ-1:0] pending,
    output logic [N_REQ-1:0] overrun
);

    state_e           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [N_REQ-1:0] r_onehot;
    logic [N_REQ-1:0] r_pending;
    logic [N_REQ-1:0] r_overrun;

    logic             w_accept;
    logic [N_REQ-1:0] w_acc_mask;
    logic [N_REQ-1:0] w_cand;
    logic [IDX_W-1:0] w_ptr_eff;
    logic [IDX_W-1:0] w_pick;
    logic             w_any;
    logic [N_REQ-1:0] w_pend_nxt;
    logic [N_REQ-1:0] w_ovr_set;
    logic [N_REQ-1:0] w_ovr_nxt;

    // Accepted bit drops out of pending/candidates unless req re-asserts it.
    assign w_accept   = (r_state == ST_PRESENT) && out_ready;
    assign w_acc_mask = w_accept ? r_onehot : '0;
    assign w_cand     = (r_pending & ~w_acc_mask) | req;
    assign w_ptr_eff  = w_accept ? IDX_W'(r_idx + IDX_W'(1)) : r_ptr;
    assign w_pend_nxt = req | (r_pending & ~w_acc_mask);
    assign w_ovr_set  = req & r_pending & ~w_acc_mask;
    assign w_ovr_nxt  = w_ovr_set | (clr_ovr ? '0 : r_overrun);

    rr_pick_4 u_pick (
        .cand (w_cand),
        .ptr  (w_ptr_eff),
        .pick (w_pick),
        .any  (w_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_onehot  <= '0;
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            r_overrun <= w_ovr_nxt;
            if (w_accept) begin
                r_ptr <= w_ptr_eff;
            end
            case (r_state)
                ST_IDLE: begin
                    if (en && w_any) begin
                        r_idx    <= w_pick;
                        r_onehot <= idx_to_onehot(w_pick);
                        r_state  <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (w_accept) begin
                        if (en && w_any) begin
                            r_idx    <= w_pick;
                            r_onehot <= idx_to_onehot(w_pick);
                        end else begin
                            r_onehot <= '0;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_onehot <= '0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid  = (r_state == ST_PRESENT);
    assign out_idx    = r_idx;
    assign out_onehot = r_onehot;
    assign pending    = r_pending;
    assign overrun    = r_overrun;

endmodule : req_encoder_4_2

// File: tb/tb_req_encoder_4_2.sv
// Directed bench for req_encoder_4_2: reset, latency, round-robin, backpressure,
// overrun/set-wins, clear and enable gating.
module tb_req_encoder_4_2;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       out_ready;
    logic       clr_ovr;
    logic       out_valid;
    logic [1:0] out_idx;
    logic [3:0] out_onehot;
    logic [3:0] pending;
    logic [3:0] overrun;

    int n_total = 0;
    int n_bad   = 0;

    req_encoder_4_2 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req        (req),
        .out_ready  (out_ready),
        .clr_ovr    (clr_ovr),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .pending    (pending),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [1:0] idx,
                           input logic [3:0] oh, input logic [3:0] pend);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, ".idx"}, 32'(out_idx), 32'(idx));
        check({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
        check({tag, ".pending"}, 32'(pending), 32'(pend));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; out_ready = 1'b0; clr_ovr = 1'b0; en = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; req = '0; out_ready = 1'b0; clr_ovr = 1'b0;
        tick(); tick();
        chk_out("rst", 1'b0, 2'd0, 4'b0000, 4'b0000);
        check("rst.idx", 32'(out_idx), 32'd0);
        check("rst.ovr", 32'(overrun), 32'd0);
        rst_n = 1'b1;

        // Single request, one-cycle latency, then accept back to idle.
        req = 4'b0100; out_ready = 1'b1; tick();
        chk_out("single.present", 1'b1, 2'd2, 4'b0100, 4'b0100);
        req = '0; tick();
        chk_out("single.accept", 1'b0, 2'd0, 4'b0000, 4'b0000);
        // ptr is now 3: req 1001 must pick 3 first, then 0.
        req = 4'b1001; tick();
        chk_out("ptr3.first", 1'b1, 2'd3, 4'b1000, 4'b1001);
        req = '0; tick();
        chk_out("ptr3.second", 1'b1, 2'd0, 4'b0001, 4'b0001);
        tick();
        chk_out("ptr3.idle", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Async reset mid-handshake; ptr=1 so 0110 presents index 1.
        req = 4'b0110; out_ready = 1'b0; tick();
        chk_out("arst.pre", 1'b1, 2'd1, 4'b0010, 4'b0110);
        req = '0;
        #2 rst_n = 1'b0;
        #1 chk_out("arst.now", 1'b0, 2'd0, 4'b0000, 4'b0000);
        tick();
        rst_n = 1'b1; tick();
        chk_out("arst.noreplay", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Round-robin from ptr=0 with continuous accept.
        req = 4'b1011; out_ready = 1'b1; tick();
        chk_out("rr.a", 1'b1, 2'd0, 4'b0001, 4'b1011);
        req = '0; tick();
        chk_out("rr.b", 1'b1, 2'd1, 4'b0010, 4'b1010);
        tick();
        chk_out("rr.c", 1'b1, 2'd3, 4'b1000, 4'b1000);
        tick();
        chk_out("rr.d", 1'b0, 2'd0, 4'b0000, 4'b0000);
        req = 4'b0011; tick();
        chk_out("wrap.a", 1'b1, 2'd0, 4'b0001, 4'b0011);
        req = '0; tick();
        chk_out("wrap.b", 1'b1, 2'd1, 4'b0010, 4'b0010);
        tick();
        chk_out("wrap.c", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Backpressure: index 0 held stable while a second request queues.
        do_reset();
        req = 4'b0001; out_ready = 1'b0; tick();
        chk_out("bp.c1", 1'b1, 2'd0, 4'b0001, 4'b0001);
        req = '0; tick();
        chk_out("bp.c2", 1'b1, 2'd0, 4'b0001, 4'b0001);
        req = 4'b0010; tick();
        chk_out("bp.c3", 1'b1, 2'd0, 4'b0001, 4'b0011);
        req = '0; tick();
        chk_out("bp.c4", 1'b1, 2'd0, 4'b0001, 4'b0011);
        tick();
        chk_out("bp.c5", 1'b1, 2'd0, 4'b0001, 4'b0011);
        check("bp.ovr", 32'(overrun), 32'd0);
        out_ready = 1'b1; tick();
        chk_out("bp.next", 1'b1, 2'd1, 4'b0010, 4'b0010);
        tick();
        chk_out("bp.idle", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Overrun on held request, set-wins on accept, then clear.
        do_reset();
        req = 4'b0001; out_ready = 1'b0; tick();
        check("ovr.c1", 32'(overrun), 32'b0000);
        tick();
        check("ovr.c2", 32'(overrun), 32'b0001);
        tick();
        check("ovr.c3", 32'(overrun), 32'b0001);
        out_ready = 1'b1; tick();
        chk_out("setwins", 1'b1, 2'd0, 4'b0001, 4'b0001);
        check("setwins.ovr", 32'(overrun), 32'b0001);
        req = '0; clr_ovr = 1'b1; tick();
        chk_out("clr.accept", 1'b0, 2'd0, 4'b0000, 4'b0000);
        check("clr.ovr", 32'(overrun), 32'b0000);

        // Clear coinciding with a new overrun event keeps the flag.
        clr_ovr = 1'b0; out_ready = 1'b0; req = 4'b0001; tick();
        tick();
        check("clrwin.pre", 32'(overrun), 32'b0001);
        clr_ovr = 1'b1; tick();
        check("clrwin.set", 32'(overrun), 32'b0001);
        req = '0; tick();
        check("clrwin.clr", 32'(overrun), 32'b0000);
        clr_ovr = 1'b0; out_ready = 1'b1; tick();
        chk_out("clrwin.idle", 1'b0, 2'd0, 4'b0000, 4'b0000);

        // Enable gating blocks loads but not capture.
        en = 1'b0; req = 4'b1000; tick();
        chk_out("en0.a", 1'b0, 2'd0, 4'b0000, 4'b1000);
        req = '0; tick();
        chk_out("en0.b", 1'b0, 2'd0, 4'b0000, 4'b1000);
        en = 1'b1; tick();
        chk_out("en1.load", 1'b1, 2'd3, 4'b1000, 4'b1000);
        tick();
        chk_out("en1.idle", 1'b0, 2'd0, 4'b0000, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_req_encoder_4_2
